reg_file_dumper: RTL and testbench

Read-side sequencer for the 8x8-bit register file (`reg_8x8_bit`). On a start pulse it walks a window of register addresses through the file's two read ports (AA/A and BA/B), fetching two registers per fetch cycle. It snapshots them into holding registers and streams the words out one per transfer on a valid/ready interface. It is the reader counterpart to the write path (WR/DA/D). It feeds debug/dump logic and serial readout of processor state.

---
 rtl/reg_file_dumper_if.sv | 11 +
 rtl/reg_file_dumper.sv | 104 ++++++++++
 tb/tb_reg_file_dumper.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_dumper_if.sv
// Output word stream of the register-file dumper: valid/ready handshake plus data.
interface reg_file_dumper_if #(
  parameter int bit_width = 8
);
  logic [bit_width-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/reg_file_dumper.sv
// Read-side sequencer for the 8x8 register file: fetches address pairs through
// the two read ports, snapshots them, and streams the words out one at a time.
module reg_file_dumper #(
  parameter int bit_width = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           first_addr,
  input  logic [3:0]           count,
  output logic [2:0]           AA,
  output logic [2:0]           BA,
  input  logic [bit_width-1:0] A,
  input  logic [bit_width-1:0] B,
  reg_file_dumper_if.master    stream,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_A,
    SEND_B,
    DONE
  } state_t;

  state_t               state, state_n;
  logic [2:0]           ptr;
  logic [3:0]           remaining;
  logic [bit_width-1:0] hold_a, hold_b;
  logic [bit_width-1:0] data_c;
  logic                 valid_c;

  assign AA = ptr;
  assign BA = ptr + 3'd1;
  assign stream.out_data  = data_c;
  assign stream.out_valid = valid_c;

  always_comb begin
    state_n = state;
    valid_c = 1'b0;
    data_c  = '0;
    busy    = (state != IDLE);
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = (count == '0) ? DONE : FETCH;
      end
      FETCH: state_n = SEND_A;
      SEND_A: begin
        valid_c = 1'b1;
        data_c  = hold_a;
        // Odd count ends here: the paired B word is never offered.
        if (stream.out_ready) state_n = (remaining == 4'd1) ? DONE : SEND_B;
      end
      SEND_B: begin
        valid_c = 1'b1;
        data_c  = hold_b;
        if (stream.out_ready) state_n = (remaining == 4'd1) ? DONE : FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start && count != '0) begin
            ptr       <= first_addr;
            remaining <= count;
          end
        end
        FETCH: begin
          hold_a <= A;
          hold_b <= B;
        end
        SEND_A: begin
          if (stream.out_ready) remaining <= remaining - 4'd1;
        end
        SEND_B: begin
          if (stream.out_ready) begin
            remaining <= remaining - 4'd1;
            ptr       <= ptr + 3'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Bench for reg_file_dumper: register file modelled as an array with combinational
// read; expected streams derived from address-window arithmetic.
module tb_reg_file_dumper;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] first_addr;
  logic [3:0] count;
  logic [2:0] AA, BA;
  logic [7:0] A, B;
  logic       busy, done;
  logic [7:0] rf [8];

  reg_file_dumper_if #(.bit_width(8)) sif ();

  reg_file_dumper #(.bit_width(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .AA         (AA),
    .BA         (BA),
    .A          (A),
    .B          (B),
    .stream     (sif.master),
    .busy       (busy),
    .done       (done)
  );

  assign A = rf[AA];
  assign B = rf[BA];

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] cap_w[$];
  int         cap_c[$];
  logic [2:0] cap_aa[$], cap_ba[$];
  int done_cyc, done_n, stab_err, busy_err, valid_err, valid_n;
  logic idle_busy;
  bit   timeout;

  function automatic int exp_xfer_cyc(int i);
    return 2 + 3 * (i / 2) + (i % 2);
  endfunction

  function automatic int exp_done_cyc(int cnt);
    return (cnt == 0) ? 1 : exp_xfer_cyc(cnt - 1) + 1;
  endfunction

  // mode: 0 ready always high, 1 random ready, 2 ready low 3 cycles after first valid
  task automatic run_dump(input logic [2:0] fa, input logic [3:0] cnt, input int mode,
                          input int ign_cyc, input int wr_cyc, input logic [2:0] wr_addr,
                          input logic [7:0] wr_val);
    int cyc, bp;
    bit seen, pv, fin;
    logic [7:0] pd;
    cap_w.delete(); cap_c.delete(); cap_aa.delete(); cap_ba.delete();
    done_cyc = -1; done_n = 0; stab_err = 0; busy_err = 0; valid_err = 0; valid_n = 0;
    idle_busy = 1'b1; seen = 0; pv = 0; fin = 0; bp = 0; pd = '0;
    @(negedge clock);
    start = 1'b1; first_addr = fa; count = cnt; sif.out_ready = 1'b1; cyc = 0;
    while (!fin && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == ign_cyc) begin
        start = 1'b1; first_addr = fa + 3'd3; count = 4'd3;
      end else if (cyc == ign_cyc + 1) start = 1'b0;
      if (cyc == wr_cyc) rf[wr_addr] = wr_val;
      case (mode)
        0: sif.out_ready = 1'b1;
        1: sif.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (sif.out_valid && !seen) begin seen = 1; bp = 3; end
          if (bp > 0) begin sif.out_ready = 1'b0; bp--; end
          else sif.out_ready = 1'b1;
        end
      endcase
      if (pv && (!sif.out_valid || sif.out_data !== pd)) stab_err++;
      pv = sif.out_valid && !sif.out_ready;
      pd = sif.out_data;
      if (sif.out_valid) valid_n++;
      if (sif.out_valid && sif.out_ready) begin cap_w.push_back(sif.out_data); cap_c.push_back(cyc); end
      if (busy && !sif.out_valid && !done) begin cap_aa.push_back(AA); cap_ba.push_back(BA); end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
        if (sif.out_valid) valid_err++;
      end
      if (done_cyc < 0 && !busy) busy_err++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin idle_busy = busy; fin = 1; end
    end
    timeout = !fin;
    sif.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; first_addr = '0; count = '0; sif.out_ready = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({sif.out_valid, busy, done, AA, BA, sif.out_data} !== {3'b000, 3'd0, 3'd1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b busy=%b done=%b AA=%0d BA=%0d data=%h, want 0 0 0 0 1 00",
               sif.out_valid, busy, done, AA, BA, sif.out_data);
    end
    reset = 1'b1;
  endtask

  // Always-ready dump: words, transfer cycles, fetch addresses and done timing.
  task automatic test_dump_timed(input string nm, input logic [2:0] fa, input int cnt, input int ign);
    logic [7:0] exp[$];
    logic [2:0] ea;
    int nf;
    for (int i = 0; i < cnt; i++) exp.push_back(rf[3'(fa + 3'(i))]);
    run_dump(fa, 4'(cnt), 0, ign, -1, 3'd0, 8'h00);
    n_cmp++;
    if (timeout) begin n_fail++; $display("FAIL %s_timeout: no done within bound", nm); end
    n_cmp++;
    if (cap_w.size() != cnt) begin
      n_fail++; $display("FAIL %s_nwords: got %0d want %0d", nm, cap_w.size(), cnt);
    end
    for (int i = 0; i < cnt && i < cap_w.size(); i++) begin
      n_cmp++;
      if (cap_w[i] !== exp[i]) begin
        n_fail++; $display("FAIL %s_word%0d: got %h want %h", nm, i, cap_w[i], exp[i]);
      end
      n_cmp++;
      if (cap_c[i] != exp_xfer_cyc(i)) begin
        n_fail++; $display("FAIL %s_cyc%0d: got N+%0d want N+%0d", nm, i, cap_c[i], exp_xfer_cyc(i));
      end
    end
    nf = (cnt + 1) / 2;
    n_cmp++;
    if (cap_aa.size() != nf) begin
      n_fail++; $display("FAIL %s_nfetch: got %0d want %0d", nm, cap_aa.size(), nf);
    end
    for (int k = 0; k < nf && k < cap_aa.size(); k++) begin
      ea = fa + 3'(2 * k);
      n_cmp++;
      if (cap_aa[k] !== ea || cap_ba[k] !== ea + 3'd1) begin
        n_fail++; $display("FAIL %s_fetch%0d: got AA=%0d BA=%0d want %0d %0d", nm, k, cap_aa[k], cap_ba[k], ea, ea + 3'd1);
      end
    end
    n_cmp++;
    if (done_cyc != exp_done_cyc(cnt) || done_n != 1) begin
      n_fail++; $display("FAIL %s_done: got cyc N+%0d x%0d want N+%0d x1", nm, done_cyc, done_n, exp_done_cyc(cnt));
    end
    n_cmp++;
    if (busy_err != 0 || idle_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy: got gaps=%0d busy_after=%b want 0 0", nm, busy_err, idle_busy);
    end
    n_cmp++;
    if (valid_n != cnt || valid_err != 0) begin
      n_fail++; $display("FAIL %s_valid: got cycles=%0d in_done=%0d want %0d 0", nm, valid_n, valid_err, cnt);
    end
  endtask

  task automatic test_backpressure();
    run_dump(3'd0, 4'd2, 2, -1, -1, 3'd0, 8'h00);
    n_cmp++;
    if (timeout || cap_w.size() != 2) begin
      n_fail++; $display("FAIL bp_nwords: got %0d timeout=%b want 2 0", cap_w.size(), timeout);
    end else begin
      n_cmp++;
      if (cap_w[0] !== 8'h10 || cap_w[1] !== 8'h11) begin
        n_fail++; $display("FAIL bp_words: got %h %h want 10 11", cap_w[0], cap_w[1]);
      end
      n_cmp++;
      if (cap_c[0] != 5 || cap_c[1] != 6) begin
        n_fail++; $display("FAIL bp_cycles: got N+%0d N+%0d want N+5 N+6", cap_c[0], cap_c[1]);
      end
    end
    n_cmp++;
    if (stab_err != 0 || valid_n != 5) begin
      n_fail++; $display("FAIL bp_hold: got unstable=%0d valid_cycles=%0d want 0 5", stab_err, valid_n);
    end
    n_cmp++;
    if (done_cyc != 7 || done_n != 1) begin
      n_fail++; $display("FAIL bp_done: got N+%0d x%0d want N+7 x1", done_cyc, done_n);
    end
  endtask

  task automatic test_snapshot();
    run_dump(3'd0, 4'd2, 0, -1, 2, 3'd1, 8'hAA);
    n_cmp++;
    if (cap_w.size() != 2 || cap_w[0] !== 8'h10 || cap_w[1] !== 8'h11) begin
      n_fail++;
      $display("FAIL snapshot: got n=%0d %h %h want 10 11", cap_w.size(),
               cap_w.size() > 0 ? cap_w[0] : 8'hxx, cap_w.size() > 1 ? cap_w[1] : 8'hxx);
    end
    run_dump(3'd0, 4'd2, 0, -1, -1, 3'd0, 8'h00);
    n_cmp++;
    if (cap_w.size() != 2 || cap_w[1] !== 8'hAA) begin
      n_fail++; $display("FAIL snapshot_written: got n=%0d last=%h want AA", cap_w.size(),
                         cap_w.size() > 1 ? cap_w[1] : 8'hxx);
    end
    rf[1] = 8'h11;
  endtask

  task automatic test_reset_mid_dump();
    int dn = 0, vn = 0;
    @(negedge clock);
    start = 1'b1; first_addr = 3'd2; count = 4'd8;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({sif.out_valid, busy, done, AA, BA, sif.out_data} !== {3'b000, 3'd0, 3'd1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b busy=%b done=%b AA=%0d BA=%0d data=%h, want 0 0 0 0 1 00",
               sif.out_valid, busy, done, AA, BA, sif.out_data);
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (done) dn++;
      if (sif.out_valid || busy) vn++;
    end
    n_cmp++;
    if (dn != 0 || vn != 0) begin
      n_fail++; $display("FAIL reset_mid_after: got done=%0d active=%0d want 0 0", dn, vn);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic [2:0] fa;
    int cnt;
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < 8; j++) rf[j] = 8'($urandom);
      fa = 3'($urandom_range(0, 7));
      cnt = $urandom_range(0, 15);
      exp.delete();
      for (int i = 0; i < cnt; i++) exp.push_back(rf[3'(fa + 3'(i))]);
      run_dump(fa, 4'(cnt), 1, -1, -1, 3'd0, 8'h00);
      n_cmp++;
      if (timeout || cap_w.size() != cnt || done_n != 1) begin
        n_fail++; $display("FAIL rand%0d_shape: got n=%0d done=%0d timeout=%b want %0d 1 0",
                           r, cap_w.size(), done_n, timeout, cnt);
      end
      for (int i = 0; i < cnt && i < cap_w.size(); i++) begin
        n_cmp++;
        if (cap_w[i] !== exp[i]) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %h want %h", r, i, cap_w[i], exp[i]);
        end
      end
      n_cmp++;
      if (stab_err != 0 || busy_err != 0 || idle_busy !== 1'b0 || valid_err != 0 || cap_aa.size() != (cnt + 1) / 2) begin
        n_fail++; $display("FAIL rand%0d_proto: got unstable=%0d busy_gaps=%0d busy_after=%b valid_in_done=%0d fetches=%0d want 0 0 0 0 %0d",
                           r, stab_err, busy_err, idle_busy, valid_err, cap_aa.size(), (cnt + 1) / 2);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 8; j++) rf[j] = 8'h10 + 8'(j);
    test_reset();
    test_dump_timed("full", 3'd0, 8, -1);
    test_dump_timed("wrap_odd", 3'd6, 5, -1);
    test_dump_timed("count0", 3'd3, 0, -1);
    test_dump_timed("start_ignored", 3'd1, 6, 3);
    test_backpressure();
    test_snapshot();
    test_reset_mid_dump();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
